// File: rtl/ysyx_201979054_trap_pkg.sv
// rtl/ysyx_201979054_trap_pkg.sv - shared types and constants for the machine-mode trap sequencer
package ysyx_201979054_trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_VECTOR,
        ST_MRET_RD,
        ST_REDIRECT
    } trap_state_t;

    // Width of the cause/interrupt code field; the largest code is 11.
    localparam int CODE_W = 4;

    localparam int unsigned CSR_MSTATUS = 0;
    localparam int unsigned CSR_MIE     = 2;
    localparam int unsigned CSR_MTVEC   = 3;
    localparam int unsigned CSR_MCAUSE  = 4;
    localparam int unsigned CSR_MEPC    = 5;
    localparam int unsigned CSR_MIP     = 6;

    localparam logic [CODE_W-1:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [CODE_W-1:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [CODE_W-1:0] CAUSE_ECALL   = 4'd11;
    localparam logic [CODE_W-1:0] IRQ_MSI       = 4'd3;
    localparam logic [CODE_W-1:0] IRQ_MTI       = 4'd7;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/ysyx_201979054_trap_prio.sv
// rtl/ysyx_201979054_trap_prio.sv - combinational trap/interrupt/mret priority encoder
module ysyx_201979054_trap_prio
    import ysyx_201979054_trap_pkg::*;
(
    input  logic              i_ecall,
    input  logic              i_ebreak,
    input  logic              i_illegal,
    input  logic              i_mret,
    input  logic              i_mie_mstatus,
    input  logic              i_mtip_mip,
    input  logic              i_msip_mip,
    input  logic              i_mtie_mie,
    input  logic              i_msie_mie,
    output logic              o_take,
    output logic              o_is_irq,
    output logic [CODE_W-1:0] o_code,
    output logic              o_is_mret
);

    logic msi_pending;
    logic mti_pending;
    logic irq_pending;

    // Pick the highest-priority event; a pending interrupt swallows an MRET at the same boundary.
    always_comb begin
        msi_pending = i_mie_mstatus & i_msip_mip & i_msie_mie;
        mti_pending = i_mie_mstatus & i_mtip_mip & i_mtie_mie;
        irq_pending = msi_pending | mti_pending;
        o_take      = 1'b0;
        o_is_irq    = 1'b0;
        o_code      = '0;
        o_is_mret   = 1'b0;
        if (i_illegal) begin
            o_take = 1'b1;
            o_code = CAUSE_ILLEGAL;
        end else if (i_ebreak) begin
            o_take = 1'b1;
            o_code = CAUSE_EBREAK;
        end else if (i_ecall) begin
            o_take = 1'b1;
            o_code = CAUSE_ECALL;
        end else if (irq_pending) begin
            o_take   = 1'b1;
            o_is_irq = 1'b1;
            o_code   = msi_pending ? IRQ_MSI : IRQ_MTI;
        end else if (i_mret) begin
            o_is_mret = 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_201979054_trap_ctrl.sv
// rtl/ysyx_201979054_trap_ctrl.sv - trap sequencer: CSR saves, vectoring, MRET and fetch redirect
module ysyx_201979054_trap_ctrl
    import ysyx_201979054_trap_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_boundary,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic                  i_ecall,
    input  logic                  i_ebreak,
    input  logic                  i_illegal,
    input  logic                  i_mret,
    input  logic                  i_mie_mstatus,
    input  logic                  i_mtip_mip,
    input  logic                  i_msip_mip,
    input  logic                  i_mtie_mie,
    input  logic                  i_msie_mie,
    input  logic [ADDR_WIDTH-1:0] i_core_read_addr,
    input  logic [DATA_WIDTH-1:0] i_csr_read_data,
    output logic [ADDR_WIDTH-1:0] o_csr_read_addr,
    output logic                  o_csr_we_1,
    output logic                  o_csr_we_2,
    output logic [ADDR_WIDTH-1:0] o_csr_waddr_1,
    output logic [ADDR_WIDTH-1:0] o_csr_waddr_2,
    output logic [DATA_WIDTH-1:0] o_csr_wdata_1,
    output logic [DATA_WIDTH-1:0] o_csr_wdata_2,
    output logic                  o_interrupt_jump,
    output logic                  o_mret_instr,
    output logic                  o_stall,
    output logic                  o_redirect_valid,
    input  logic                  i_redirect_ready,
    output logic [DATA_WIDTH-1:0] o_redirect_pc
);

    trap_state_t           state_q;
    trap_state_t           state_d;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [CODE_W-1:0]     code_q;
    logic                  irq_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;
    logic [DATA_WIDTH-1:0] redirect_pc_d;

    logic                  prio_take;
    logic                  prio_is_irq;
    logic [CODE_W-1:0]     prio_code;
    logic                  prio_is_mret;
    logic                  at_boundary;

    logic [1:0]            mtvec_mode;
    logic [DATA_WIDTH-1:0] read_aligned;
    logic [DATA_WIDTH-1:0] vector_target;

    ysyx_201979054_trap_prio u_prio (
        .i_ecall       (i_ecall),
        .i_ebreak      (i_ebreak),
        .i_illegal     (i_illegal),
        .i_mret        (i_mret),
        .i_mie_mstatus (i_mie_mstatus),
        .i_mtip_mip    (i_mtip_mip),
        .i_msip_mip    (i_msip_mip),
        .i_mtie_mie    (i_mtie_mie),
        .i_msie_mie    (i_msie_mie),
        .o_take        (prio_take),
        .o_is_irq      (prio_is_irq),
        .o_code        (prio_code),
        .o_is_mret     (prio_is_mret)
    );

    assign at_boundary   = (state_q == ST_IDLE) & i_boundary;
    assign o_redirect_pc = redirect_pc_q;

    // Vector target from mtvec; the same 4-byte alignment serves the mepc read for MRET.
    always_comb begin
        mtvec_mode   = i_csr_read_data[1:0];
        read_aligned = {i_csr_read_data[DATA_WIDTH-1:2], 2'b00};
        if (irq_q && (mtvec_mode == MTVEC_VECTORED)) begin
            vector_target = read_aligned + (DATA_WIDTH'(code_q) << 2);
        end else begin
            vector_target = read_aligned;
        end
    end

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture PC and cause of the trap chosen at the boundary.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pc_q   <= '0;
            code_q <= '0;
            irq_q  <= 1'b0;
        end else if (at_boundary && prio_take) begin
            pc_q   <= i_pc;
            code_q <= prio_code;
            irq_q  <= prio_is_irq;
        end
    end

    // Redirect PC register, held stable while the fetch stage stalls ready.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            redirect_pc_q <= '0;
        end else begin
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Next-state logic and per-state CSR port / strobe outputs.
    always_comb begin
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        o_csr_read_addr  = i_core_read_addr;
        o_csr_we_1       = 1'b0;
        o_csr_we_2       = 1'b0;
        o_csr_waddr_1    = '0;
        o_csr_waddr_2    = '0;
        o_csr_wdata_1    = '0;
        o_csr_wdata_2    = '0;
        o_interrupt_jump = 1'b0;
        o_mret_instr     = 1'b0;
        o_stall          = 1'b1;
        o_redirect_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_stall = 1'b0;
                if (at_boundary && prio_take) begin
                    state_d = ST_SAVE;
                end else if (at_boundary && prio_is_mret) begin
                    state_d = ST_MRET_RD;
                end
            end
            ST_SAVE: begin
                o_csr_we_1       = 1'b1;
                o_csr_waddr_1    = ADDR_WIDTH'(CSR_MEPC);
                o_csr_wdata_1    = pc_q;
                o_csr_we_2       = 1'b1;
                o_csr_waddr_2    = ADDR_WIDTH'(CSR_MCAUSE);
                o_csr_wdata_2    = {irq_q, {(DATA_WIDTH-1-CODE_W){1'b0}}, code_q};
                o_interrupt_jump = 1'b1;
                state_d          = ST_VECTOR;
            end
            ST_VECTOR: begin
                o_csr_read_addr = ADDR_WIDTH'(CSR_MTVEC);
                redirect_pc_d   = vector_target;
                state_d         = ST_REDIRECT;
            end
            ST_MRET_RD: begin
                o_csr_read_addr = ADDR_WIDTH'(CSR_MEPC);
                o_mret_instr    = 1'b1;
                redirect_pc_d   = read_aligned;
                state_d         = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                o_redirect_valid = 1'b1;
                if (i_redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_201979054_trap_ctrl.sv
// tb/tb_ysyx_201979054_trap_ctrl.sv - scoreboard bench for the trap sequencer
module tb_ysyx_201979054_trap_ctrl;

    logic        clk = 1'b0;
    logic        arst;
    logic        i_boundary;
    logic [63:0] i_pc;
    logic        i_ecall, i_ebreak, i_illegal, i_mret;
    logic        i_mie_mstatus, i_mtip_mip, i_msip_mip, i_mtie_mie, i_msie_mie;
    logic [2:0]  i_core_read_addr;
    logic [63:0] i_csr_read_data;
    logic [2:0]  o_csr_read_addr;
    logic        o_csr_we_1, o_csr_we_2;
    logic [2:0]  o_csr_waddr_1, o_csr_waddr_2;
    logic [63:0] o_csr_wdata_1, o_csr_wdata_2;
    logic        o_interrupt_jump, o_mret_instr, o_stall;
    logic        o_redirect_valid, i_redirect_ready;
    logic [63:0] o_redirect_pc;

    logic [63:0] csr [0:7];
    assign i_csr_read_data = csr[o_csr_read_addr];

    ysyx_201979054_trap_ctrl dut (
        .clk              (clk),
        .arst             (arst),
        .i_boundary       (i_boundary),
        .i_pc             (i_pc),
        .i_ecall          (i_ecall),
        .i_ebreak         (i_ebreak),
        .i_illegal        (i_illegal),
        .i_mret           (i_mret),
        .i_mie_mstatus    (i_mie_mstatus),
        .i_mtip_mip       (i_mtip_mip),
        .i_msip_mip       (i_msip_mip),
        .i_mtie_mie       (i_mtie_mie),
        .i_msie_mie       (i_msie_mie),
        .i_core_read_addr (i_core_read_addr),
        .i_csr_read_data  (i_csr_read_data),
        .o_csr_read_addr  (o_csr_read_addr),
        .o_csr_we_1       (o_csr_we_1),
        .o_csr_we_2       (o_csr_we_2),
        .o_csr_waddr_1    (o_csr_waddr_1),
        .o_csr_waddr_2    (o_csr_waddr_2),
        .o_csr_wdata_1    (o_csr_wdata_1),
        .o_csr_wdata_2    (o_csr_wdata_2),
        .o_interrupt_jump (o_interrupt_jump),
        .o_mret_instr     (o_mret_instr),
        .o_stall          (o_stall),
        .o_redirect_valid (o_redirect_valid),
        .i_redirect_ready (i_redirect_ready),
        .o_redirect_pc    (o_redirect_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int t; logic [63:0] pc; logic [63:0] cause; } save_t;
    typedef struct { int t; logic [63:0] pc; } redir_t;

    save_t  save_q[$];
    redir_t redir_q[$];
    int     mret_q[$];

    save_t       ms;
    redir_t      mr;
    int          mt;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [63:0] held_pc    = '0;

    // Monitor: compare every DUT output event against the expected queues.
    always @(negedge clk) begin
        if (arst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (o_csr_we_1 || o_csr_we_2 || o_interrupt_jump) begin
                if (save_q.size() == 0) begin
                    chk("unexpected_save", 1, 0);
                end else begin
                    ms = save_q.pop_front();
                    chk("save_cycle", cyc, ms.t);
                    chk("we_1", o_csr_we_1, 1);
                    chk("we_2", o_csr_we_2, 1);
                    chk("jump", o_interrupt_jump, 1);
                    chk("waddr_1", o_csr_waddr_1, 5);
                    chk("waddr_2", o_csr_waddr_2, 4);
                    chk("mepc", o_csr_wdata_1, ms.pc);
                    chk("mcause", o_csr_wdata_2, ms.cause);
                end
            end
            if (o_mret_instr) begin
                if (mret_q.size() == 0) begin
                    chk("unexpected_mret", 1, 0);
                end else begin
                    mt = mret_q.pop_front();
                    chk("mret_cycle", cyc, mt);
                    chk("mret_raddr", o_csr_read_addr, 5);
                end
            end
            if (o_redirect_valid && !prev_valid) begin
                if (redir_q.size() == 0) begin
                    chk("unexpected_redirect", 1, 0);
                end else begin
                    mr = redir_q.pop_front();
                    chk("redirect_cycle", cyc, mr.t);
                    chk("redirect_pc", o_redirect_pc, mr.pc);
                end
                held_pc = o_redirect_pc;
            end else if (prev_valid && !prev_ready) begin
                chk("valid_held", o_redirect_valid, 1);
                chk("pc_held", o_redirect_pc, held_pc);
            end
            prev_valid = o_redirect_valid;
            prev_ready = i_redirect_ready;
        end
    end

    task automatic noise(input bit with_boundary);
        i_boundary    = with_boundary ? 1'($urandom_range(0, 1)) : 1'b0;
        i_pc          = {$urandom, $urandom};
        i_illegal     = 1'($urandom_range(0, 1));
        i_ebreak      = 1'($urandom_range(0, 1));
        i_ecall       = 1'($urandom_range(0, 1));
        i_mret        = 1'($urandom_range(0, 1));
        i_mie_mstatus = 1'($urandom_range(0, 1));
        i_mtip_mip    = 1'($urandom_range(0, 1));
        i_msip_mip    = 1'($urandom_range(0, 1));
        i_mtie_mie    = 1'($urandom_range(0, 1));
        i_msie_mie    = 1'($urandom_range(0, 1));
    endtask

    // Drive ready until the sequence returns to idle; boundary noise must be ignored meanwhile.
    task automatic run_seq(input bit hold);
        int n    = 0;
        int vcnt = 0;
        while (o_stall && n < 80) begin
            if (o_redirect_valid) vcnt++;
            if (hold) i_redirect_ready = (vcnt > 3);
            else      i_redirect_ready = (n > 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
            noise(1'b1);
            @(posedge clk); #1;
            n++;
        end
        chk("seq_timeout", o_stall, 0);
        i_boundary       = 1'b0;
        i_redirect_ready = 1'b0;
    endtask

    // ev = {illegal, ebreak, ecall, mret, mie, mtip, msip, mtie, msie}
    task automatic do_boundary(input logic [63:0] pc, input logic [8:0] ev,
                               input logic [63:0] mtvec, input logic [63:0] mepc, input bit hold);
        bit          msi, mti, is_irq;
        int          kind;
        int          code;
        logic [63:0] cause, target;
        csr[3] = mtvec;
        csr[5] = mepc;
        i_pc = pc;
        {i_illegal, i_ebreak, i_ecall, i_mret, i_mie_mstatus,
         i_mtip_mip, i_msip_mip, i_mtie_mie, i_msie_mie} = ev;
        i_boundary = 1'b1;
        msi = ev[4] && ev[2] && ev[0];
        mti = ev[4] && ev[3] && ev[1];
        kind = 1; is_irq = 0; code = 0;
        if (ev[8])      code = 2;
        else if (ev[7]) code = 3;
        else if (ev[6]) code = 11;
        else if (msi) begin is_irq = 1; code = 3; end
        else if (mti) begin is_irq = 1; code = 7; end
        else if (ev[5]) kind = 2;
        else kind = 0;
        if (kind == 1) begin
            cause  = is_irq ? (64'h8000_0000_0000_0000 + 64'(code)) : 64'(code);
            target = mtvec - (mtvec % 4);
            if (is_irq && (mtvec % 4 == 1)) target = target + 64'(4 * code);
            save_q.push_back('{cyc + 1, pc, cause});
            redir_q.push_back('{cyc + 3, target});
        end else if (kind == 2) begin
            mret_q.push_back(cyc + 1);
            redir_q.push_back('{cyc + 2, mepc - (mepc % 4)});
        end
        @(posedge clk); #1;
        i_boundary = 1'b0;
        if (kind == 0) chk("no_trap_stall", o_stall, 0);
        else           run_seq(hold);
    endtask

    task automatic reset_mid_vector();
        csr[3] = 64'h8000_0000;
        i_pc = 64'h1234;
        {i_illegal, i_ebreak, i_ecall, i_mret, i_mie_mstatus,
         i_mtip_mip, i_msip_mip, i_mtie_mie, i_msie_mie} = 9'b100000000;
        i_boundary = 1'b1;
        save_q.push_back('{cyc + 1, 64'h1234, 64'd2});
        @(posedge clk); #1;
        i_boundary = 1'b0;
        @(posedge clk); #1;
        chk("vector_raddr", o_csr_read_addr, 3);
        arst = 1'b1;
        #1;
        chk("rst_stall", o_stall, 0);
        chk("rst_valid", o_redirect_valid, 0);
        chk("rst_pc", o_redirect_pc, 0);
        chk("rst_we", {o_csr_we_1, o_csr_we_2, o_interrupt_jump, o_mret_instr}, 0);
        chk("rst_raddr", o_csr_read_addr, i_core_read_addr);
        @(posedge clk); #1;
        arst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_rst_idle", o_stall, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) csr[i] = '0;
        arst = 1'b1;
        i_redirect_ready = 1'b0;
        i_core_read_addr = 3'd6;
        noise(1'b0);
        @(negedge clk);
        chk("reset_raddr", o_csr_read_addr, 6);
        chk("reset_stall", o_stall, 0);
        chk("reset_valid", o_redirect_valid, 0);
        chk("reset_pc", o_redirect_pc, 0);
        chk("reset_strobes", {o_csr_we_1, o_csr_we_2, o_interrupt_jump, o_mret_instr}, 0);
        chk("reset_wdata", o_csr_wdata_1 | o_csr_wdata_2, 0);
        @(posedge clk); #1;
        arst = 1'b0;
        @(posedge clk); #1;

        do_boundary(64'h8000_0100, 9'b100000000, 64'h8000_0000, 64'h0, 1'b0);
        do_boundary(64'h8000_0400, 9'b000011010, 64'h8000_0001, 64'h0, 1'b0);
        do_boundary(64'h8000_0500, 9'b001011111, 64'h8000_0001, 64'h0, 1'b0);
        do_boundary(64'h8000_0600, 9'b000100000, 64'h0, 64'h8000_0204, 1'b1);
        do_boundary(64'h8000_0700, 9'b000001010, 64'h8000_0000, 64'h0, 1'b0);
        do_boundary(64'h8000_0800, 9'b000110101, 64'h0100_0001, 64'h5555, 1'b0);
        do_boundary(64'h8000_0900, 9'b000011010, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0, 1'b0);
        reset_mid_vector();

        for (int it = 0; it < 200; it++) begin
            logic [63:0] mtv;
            repeat ($urandom_range(0, 2)) begin
                noise(1'b0);
                i_core_read_addr = 3'($urandom_range(0, 7));
                @(posedge clk); #1;
                chk("idle_no_stall", o_stall, 0);
            end
            mtv = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) mtv[1:0] = 2'b01;
            do_boundary({$urandom, $urandom},
                        {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                         ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                         5'($urandom_range(0, 31))},
                        mtv, {$urandom, $urandom}, 1'b0);
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("sb_save_empty", save_q.size(), 0);
        chk("sb_redir_empty", redir_q.size(), 0);
        chk("sb_mret_empty", mret_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_201979054_trap_ctrl.md
# ysyx_201979054_trap_ctrl

Machine-mode trap sequencer that sits between the core's control unit and the CSR file. At instruction boundaries it decides whether to take an exception, an interrupt or an MRET. It owns both CSR write ports and the CSR read port while a trap is in progress, and drives the `mepc`/`mcause` saves and the interrupt-jump/MRET strobes. It then hands the fetch stage a redirect PC through a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 64, CSR/PC width
- `ADDR_WIDTH`, 3, CSR file address width
- `clk` in 1: clock
- `arst` in 1: reset, asynchronous, active-high
- `i_boundary` in 1: core is at an instruction boundary; `i_pc` and the event inputs are valid
- `i_pc` in DATA_WIDTH: PC of the instruction at the boundary
- `i_ecall`, `i_ebreak`, `i_illegal`, `i_mret` in 1 each: decoded events, sampled only with `i_boundary`
- `i_mie_mstatus`, `i_mtip_mip`, `i_msip_mip`, `i_mtie_mie`, `i_msie_mie` in 1 each: CSR status bits
- `i_core_read_addr` in ADDR_WIDTH: core CSR read address, passed through in IDLE
- `i_csr_read_data` in DATA_WIDTH: CSR file read data, combinational
- `o_csr_read_addr` out ADDR_WIDTH: CSR file read address
- `o_csr_we_1`, `o_csr_we_2` out 1: CSR write enables
- `o_csr_waddr_1`, `o_csr_waddr_2` out ADDR_WIDTH: CSR write addresses
- `o_csr_wdata_1`, `o_csr_wdata_2` out DATA_WIDTH: CSR write data
- `o_interrupt_jump` out 1: one-cycle pulse that makes the CSR file clear MIE and set MPIE=MIE
- `o_mret_instr` out 1: one-cycle pulse that makes the CSR file set MIE=MPIE
- `o_stall` out 1: core must hold; high in every non-IDLE state
- `o_redirect_valid` out 1, `i_redirect_ready` in 1, `o_redirect_pc` out DATA_WIDTH: fetch redirect handshake

## Operation
- CSR indices: mstatus 0, mie 2, mtvec 3, mcause 4, mepc 5, mip 6.
- Pending interrupt: `irq = i_mie_mstatus & ((i_msip_mip & i_msie_mie) | (i_mtip_mip & i_mtie_mie))`.
- Priority at a boundary, highest first: illegal (cause 2), ebreak (3), ecall (11), MSI (interrupt, code 3), MTI (interrupt, code 7), MRET.
- MSI beats MTI when both are pending.
- An interrupt pre-empts an MRET at the same boundary. `mepc` is then the MRET's PC, and the MRET is not executed.
- `mcause` = `{is_irq, (DATA_WIDTH-1)'(code)}`, so bit 63 is set for interrupts.
- FSM states:
  - IDLE: read address = `i_core_read_addr`, no writes.
    - Trap chosen at the boundary: latch PC, cause and is_irq, go to SAVE.
    - MRET chosen: go to MRET_RD.
  - SAVE (1 cycle): port 1 writes `mepc` = latched PC; port 2 writes `mcause`; `o_interrupt_jump` = 1; go to VECTOR.
  - VECTOR (1 cycle): read address 3; compute target from `mtvec`, register it into `o_redirect_pc`, go to REDIRECT.
    - mode = `mtvec[1:0]`, base = `{mtvec[DATA_WIDTH-1:2], 2'b00}`.
    - mode 1 with interrupt: target = base + 4·code.
    - Otherwise (mode 0, 2 or 3, or any exception): target = base.
    - Addition wraps at DATA_WIDTH.
  - MRET_RD (1 cycle): read address 5; `o_mret_instr` = 1; `o_redirect_pc` = `mepc` & ~3; go to REDIRECT.
  - REDIRECT: `o_redirect_valid` = 1 with `o_redirect_pc` stable; go to IDLE in the cycle `valid & ready`.
- Event inputs are ignored outside IDLE and when `i_boundary` = 0.
- Interrupts arriving during a sequence are evaluated at the next boundary.

## Timing
- Reset values: FSM IDLE; latched PC/cause 0; all outputs 0 except `o_csr_read_addr` = `i_core_read_addr`.
- `arst` mid-sequence aborts immediately, with no partial CSR writes after release.
- Trap latency: boundary cycle T, SAVE T+1, VECTOR T+2, `o_redirect_valid` from T+3.
- MRET latency: boundary T, MRET_RD T+1, `o_redirect_valid` from T+2.
- Strobes and writes last exactly one cycle per sequence.
- Ready may be low for any number of cycles; valid and PC must hold.
- Back-to-back: a boundary in the cycle after the handshake is accepted normally.

## Structure
- Shared package `ysyx_201979054_trap_pkg`: state enum; CSR index constants; cause codes (2, 3, 11, 3, 7); mtvec mode constants.
- One sub-module: `ysyx_201979054_trap_prio`, a combinational priority encoder producing take, is_irq, code and is_mret.
- FSM, latches and target computation stay in the top.

## Test plan
- Illegal at PC 0x8000_0100, mtvec 0x8000_0000 → T+1: `mepc` = 0x8000_0100, `mcause` = 2, jump pulse; T+3: redirect 0x8000_0000.
- MTIP+MTIE+MIE, mtvec 0x8000_0001 → `mcause` = 0x8000_0000_0000_0007; redirect 0x8000_001C.
- MSI and MTI pending together with ecall at the same boundary → `mcause` = 11; redirect = base.
- MRET with `mepc` = 0x8000_0204 → T+1 `o_mret_instr` pulse; redirect 0x8000_0204; `i_redirect_ready` low 3 cycles → valid and PC held, IDLE on accept.
- MIE = 0 with MTIP/MTIE = 1 → no trap, stall stays 0.
- `arst` during VECTOR → next cycle IDLE, all outputs 0.
